prv_trap_ctrl: RTL

Trap and return sequencer for the privilege block. It prioritises pipeline exceptions, RISC-MGMT exceptions and enabled machine interrupts, then waits for the hazard unit to drain the pipeline. It then commits mepc/mcause/mtval and the mstatus push, and redirects fetch through `insert_pc`/`priv_pc`. It also sequences `mret` (mstatus pop plus redirect to mepc). It sits inside the priv block, between the pipeline-facing signals and the CSR file.

---
 rtl/machine_mode_types_1_12_pkg.sv | 60 ++++++
 rtl/prv_trap_prio.sv | 84 ++++++++
 rtl/prv_trap_ctrl.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/machine_mode_types_1_12_pkg.sv
// Shared types and constants for the machine-mode trap sequencer:
// sequencer state enum, mcause code points, the RISC-MGMT cause base and
// small helpers for trap value selection and vector base alignment.
package machine_mode_types_1_12_pkg;

    // Default number of RISC-MGMT extensions (must not exceed 8 so that
    // 24 + index still fits the 5-bit cause code field).
    localparam int NUM_EXTENSIONS = 4;

    // Synchronous exception cause codes
    localparam logic [4:0] EXC_INSN_MAL     = 5'd0;
    localparam logic [4:0] EXC_INSN_FAULT   = 5'd1;
    localparam logic [4:0] EXC_ILLEGAL_INSN = 5'd2;
    localparam logic [4:0] EXC_BREAKPOINT   = 5'd3;
    localparam logic [4:0] EXC_LOAD_MAL     = 5'd4;
    localparam logic [4:0] EXC_LOAD_FAULT   = 5'd5;
    localparam logic [4:0] EXC_STORE_MAL    = 5'd6;
    localparam logic [4:0] EXC_STORE_FAULT  = 5'd7;
    localparam logic [4:0] EXC_ENV_CALL_M   = 5'd11;

    // Machine interrupt cause codes
    localparam logic [4:0] INT_M_SOFT  = 5'd3;
    localparam logic [4:0] INT_M_TIMER = 5'd7;
    localparam logic [4:0] INT_M_EXT   = 5'd11;

    // RISC-MGMT exceptions are reported as base + extension index
    localparam logic [4:0] RMGMT_CAUSE_BASE = 5'd24;

    typedef enum logic [2:0] {
        TRAP_IDLE         = 3'd0,
        TRAP_DRAIN        = 3'd1,
        TRAP_COMMIT       = 3'd2,
        TRAP_REDIRECT     = 3'd3,
        TRAP_RET_DRAIN    = 3'd4,
        TRAP_RET_REDIRECT = 3'd5
    } trap_state_t;

    // Only misaligned/fault exceptions report the faulting address in mtval
    function automatic logic has_tval(input logic is_int, input logic [4:0] code);
        logic res;
        res = 1'b0;
        if (is_int) begin
            res = 1'b0;
        end else begin
            case (code)
                EXC_INSN_MAL, EXC_INSN_FAULT,
                EXC_LOAD_MAL, EXC_LOAD_FAULT,
                EXC_STORE_MAL, EXC_STORE_FAULT: res = 1'b1;
                default:                        res = 1'b0;
            endcase
        end
        return res;
    endfunction

    // Word-aligned base of a vector/return address register
    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/prv_trap_prio.sv
// Combinational trap priority encoder: picks the highest-priority pending
// exception, then RISC-MGMT exception, then qualified machine interrupt,
// and reports {valid, is_int, code}.
module prv_trap_prio
    import machine_mode_types_1_12_pkg::*;
#(
    parameter int NUM_EXT = NUM_EXTENSIONS,
    localparam int EXT_W = (NUM_EXT > 1) ? $clog2(NUM_EXT) : 1
) (
    input  logic             i_fault_insn,
    input  logic             i_mal_insn,
    input  logic             i_illegal_insn,
    input  logic             i_fault_l,
    input  logic             i_mal_l,
    input  logic             i_fault_s,
    input  logic             i_mal_s,
    input  logic             i_breakpoint,
    input  logic             i_env_m,
    input  logic             i_ex_rmgmt,
    input  logic [EXT_W-1:0] i_ex_rmgmt_cause,
    input  logic             i_timer_int,
    input  logic             i_soft_int,
    input  logic             i_ext_int,
    input  logic             i_mtie,
    input  logic             i_msie,
    input  logic             i_meie,
    input  logic             i_mstatus_mie,
    output logic             o_valid,
    output logic             o_is_int,
    output logic [4:0]       o_code
);

    logic       w_ext_q;
    logic       w_soft_q;
    logic       w_timer_q;
    logic [4:0] w_rmgmt_code;

    assign w_ext_q      = i_mstatus_mie & i_meie & i_ext_int;
    assign w_soft_q     = i_mstatus_mie & i_msie & i_soft_int;
    assign w_timer_q    = i_mstatus_mie & i_mtie & i_timer_int;
    assign w_rmgmt_code = RMGMT_CAUSE_BASE + 5'(i_ex_rmgmt_cause);

    // Fixed-priority selection; every exception outranks every interrupt
    always_comb begin
        o_valid  = 1'b1;
        o_is_int = 1'b0;
        o_code   = 5'd0;
        if (i_breakpoint) begin
            o_code = EXC_BREAKPOINT;
        end else if (i_fault_insn) begin
            o_code = EXC_INSN_FAULT;
        end else if (i_illegal_insn) begin
            o_code = EXC_ILLEGAL_INSN;
        end else if (i_mal_insn) begin
            o_code = EXC_INSN_MAL;
        end else if (i_env_m) begin
            o_code = EXC_ENV_CALL_M;
        end else if (i_mal_s) begin
            o_code = EXC_STORE_MAL;
        end else if (i_mal_l) begin
            o_code = EXC_LOAD_MAL;
        end else if (i_fault_s) begin
            o_code = EXC_STORE_FAULT;
        end else if (i_fault_l) begin
            o_code = EXC_LOAD_FAULT;
        end else if (i_ex_rmgmt) begin
            o_code = w_rmgmt_code;
        end else if (w_ext_q) begin
            o_is_int = 1'b1;
            o_code   = INT_M_EXT;
        end else if (w_soft_q) begin
            o_is_int = 1'b1;
            o_code   = INT_M_SOFT;
        end else if (w_timer_q) begin
            o_is_int = 1'b1;
            o_code   = INT_M_TIMER;
        end else begin
            o_valid  = 1'b0;
            o_is_int = 1'b0;
            o_code   = 5'd0;
        end
    end

endmodule

// File: rtl/prv_trap_ctrl.sv
// Trap and mret sequencer for the privilege block. Detects a trap in IDLE,
// latches mcause/mepc/mtval, waits for the pipeline to drain, commits the
// CSR write plus mstatus push, then redirects fetch to the trap vector.
// mret drains, pops mstatus and redirects to mepc.
// Optional feature macro: PRV_TRAP_VECTORED_EN (vectored interrupt targets
// when mtvec[1:0]==2'b01); when undefined the target is always the base.
module prv_trap_ctrl
    import machine_mode_types_1_12_pkg::*;
#(
    parameter int NUM_EXT = NUM_EXTENSIONS,
    localparam int EXT_W = (NUM_EXT > 1) ? $clog2(NUM_EXT) : 1
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             fault_insn,
    input  logic             mal_insn,
    input  logic             illegal_insn,
    input  logic             fault_l,
    input  logic             mal_l,
    input  logic             fault_s,
    input  logic             mal_s,
    input  logic             breakpoint,
    input  logic             env_m,
    input  logic             ex_rmgmt,
    input  logic [EXT_W-1:0] ex_rmgmt_cause,
    input  logic             timer_int,
    input  logic             soft_int,
    input  logic             ext_int,
    input  logic             mtie,
    input  logic             msie,
    input  logic             meie,
    input  logic             mstatus_mie,
    input  logic             ret,
    input  logic             pipe_clear,
    input  logic [31:0]      epc,
    input  logic [31:0]      badaddr,
    input  logic [31:0]      mtvec,
    input  logic [31:0]      mepc_r,
    output logic             intr,
    output logic             insert_pc,
    output logic [31:0]      priv_pc,
    output logic             trap_we,
    output logic [31:0]      mcause_w,
    output logic [31:0]      mepc_w,
    output logic [31:0]      mtval_w,
    output logic             mstatus_push,
    output logic             mstatus_pop,
    output logic             busy
);

    trap_state_t r_state;
    trap_state_t w_next;

    logic        w_valid;
    logic        w_is_int;
    logic [4:0]  w_code;
    logic        w_take;
    logic [31:0] w_target;
    logic [31:0] w_priv_pc_nxt;
    logic        w_unused;

    logic        r_trap_we;
    logic        r_push;
    logic        r_pop;
    logic        r_insert;
    logic        r_intr_hold;
    logic        r_busy;
    logic [31:0] r_priv_pc;
    logic [31:0] r_mcause;
    logic [31:0] r_mepc;
    logic [31:0] r_mtval;

    prv_trap_prio #(
        .NUM_EXT (NUM_EXT)
    ) u_prio (
        .i_fault_insn     (fault_insn),
        .i_mal_insn       (mal_insn),
        .i_illegal_insn   (illegal_insn),
        .i_fault_l        (fault_l),
        .i_mal_l          (mal_l),
        .i_fault_s        (fault_s),
        .i_mal_s          (mal_s),
        .i_breakpoint     (breakpoint),
        .i_env_m          (env_m),
        .i_ex_rmgmt       (ex_rmgmt),
        .i_ex_rmgmt_cause (ex_rmgmt_cause),
        .i_timer_int      (timer_int),
        .i_soft_int       (soft_int),
        .i_ext_int        (ext_int),
        .i_mtie           (mtie),
        .i_msie           (msie),
        .i_meie           (meie),
        .i_mstatus_mie    (mstatus_mie),
        .o_valid          (w_valid),
        .o_is_int         (w_is_int),
        .o_code           (w_code)
    );

    // Trap requests only count while idle; ret loses to a simultaneous trap
    assign w_take = (r_state == TRAP_IDLE) && w_valid;

`ifdef PRV_TRAP_VECTORED_EN
    assign w_target = ((mtvec[1:0] == 2'b01) && r_mcause[31])
                    ? (align_word(mtvec) + {25'd0, r_mcause[4:0], 2'b00})
                    : align_word(mtvec);
`else
    assign w_target = align_word(mtvec);
`endif

    // Mode bits of the vector/return registers are don't-care here
    assign w_unused = ^{mtvec[1:0], mepc_r[1:0]};

    // Next-state selection for the trap / return sequence
    always_comb begin
        w_next = r_state;
        case (r_state)
            TRAP_IDLE: begin
                if (w_valid) begin
                    w_next = TRAP_DRAIN;
                end else if (ret) begin
                    w_next = TRAP_RET_DRAIN;
                end else begin
                    w_next = TRAP_IDLE;
                end
            end
            TRAP_DRAIN: begin
                if (pipe_clear) begin
                    w_next = TRAP_COMMIT;
                end else begin
                    w_next = TRAP_DRAIN;
                end
            end
            TRAP_COMMIT:   w_next = TRAP_REDIRECT;
            TRAP_REDIRECT: w_next = TRAP_IDLE;
            TRAP_RET_DRAIN: begin
                if (pipe_clear) begin
                    w_next = TRAP_RET_REDIRECT;
                end else begin
                    w_next = TRAP_RET_DRAIN;
                end
            end
            TRAP_RET_REDIRECT: w_next = TRAP_IDLE;
            default:           w_next = TRAP_IDLE;
        endcase
    end

    // Redirect target to present in the cycle the next state is entered
    always_comb begin
        w_priv_pc_nxt = 32'd0;
        case (w_next)
            TRAP_REDIRECT:     w_priv_pc_nxt = w_target;
            TRAP_RET_REDIRECT: w_priv_pc_nxt = align_word(mepc_r);
            default:           w_priv_pc_nxt = 32'd0;
        endcase
    end

    // State register plus strobes registered from the next state
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state     <= TRAP_IDLE;
            r_trap_we   <= 1'b0;
            r_push      <= 1'b0;
            r_pop       <= 1'b0;
            r_insert    <= 1'b0;
            r_intr_hold <= 1'b0;
            r_busy      <= 1'b0;
            r_priv_pc   <= 32'd0;
        end else begin
            r_state     <= w_next;
            r_trap_we   <= (w_next == TRAP_COMMIT);
            r_push      <= (w_next == TRAP_COMMIT);
            r_pop       <= (w_next == TRAP_RET_REDIRECT);
            r_insert    <= (w_next == TRAP_REDIRECT) || (w_next == TRAP_RET_REDIRECT);
            r_intr_hold <= (w_next == TRAP_DRAIN) || (w_next == TRAP_COMMIT) ||
                           (w_next == TRAP_REDIRECT);
            r_busy      <= (w_next != TRAP_IDLE);
            r_priv_pc   <= w_priv_pc_nxt;
        end
    end

    // Capture CSR write data on the detection edge
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_mcause <= 32'd0;
            r_mepc   <= 32'd0;
            r_mtval  <= 32'd0;
        end else if (w_take) begin
            r_mcause <= {w_is_int, 26'd0, w_code};
            r_mepc   <= epc;
            r_mtval  <= has_tval(w_is_int, w_code) ? badaddr : 32'd0;
        end else begin
            r_mcause <= r_mcause;
            r_mepc   <= r_mepc;
            r_mtval  <= r_mtval;
        end
    end

    assign intr         = r_intr_hold | w_take;
    assign insert_pc    = r_insert;
    assign priv_pc      = r_priv_pc;
    assign trap_we      = r_trap_we;
    assign mcause_w     = r_mcause;
    assign mepc_w       = r_mepc;
    assign mtval_w      = r_mtval;
    assign mstatus_push = r_push;
    assign mstatus_pop  = r_pop;
    assign busy         = r_busy;

endmodule
